// File: rtl/dfc_rx_buffer_pkg.sv
// Shared definitions for the DFC link (receiver and sender).
//   DFC_GO / DFC_STOP : encoding of the flow-control wire (c_drdy)
//   clog2()           : ceiling log2 for sizing pointers and counters
package dfc_rx_buffer_pkg;

    localparam logic DFC_GO   = 1'b1;
    localparam logic DFC_STOP = 1'b0;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dfc_rx_buffer_mem.sv
// Storage array for the DFC receive buffer.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : write data
//   rd_addr : read index (asynchronous read)
//   rd_data : data at rd_addr
module dfc_rx_buffer_mem #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int aw    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [aw-1:0]    wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic [aw-1:0]    rd_addr,
    output logic [width-1:0] rd_data
);

    // Data storage is deliberately not reset; validity is tracked by the count.
    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dfc_rx_buffer.sv
// Receive end of a delayed-flow-control link. Beats arriving on c_srdy are
// pushed unconditionally into a skid FIFO and re-presented on an srdy/drdy
// producer interface. c_drdy is a registered "keep sending" indication that
// drops early enough to absorb `delay` in-flight beats.
//   clk, reset        : clock, synchronous active-high reset
//   c_srdy, c_data    : incoming beat (no backpressure on the beat itself)
//   c_drdy            : registered flow control back to the sender
//   p_srdy, p_drdy    : head-entry valid / downstream accept
//   p_data            : head-entry data
//   usage             : current occupancy
//   overflow          : sticky, set when a beat was dropped on a full FIFO
module dfc_rx_buffer
    import dfc_rx_buffer_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int delay = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        c_srdy,
    input  logic [width-1:0]            c_data,
    output logic                        c_drdy,
    output logic                        p_srdy,
    input  logic                        p_drdy,
    output logic [width-1:0]            p_data,
    output logic [clog2(depth+1)-1:0]   usage,
    output logic                        overflow
);

    localparam int CW = clog2(depth + 1);
    localparam int PW = clog2(depth);
    localparam logic [CW-1:0] DEPTH_C    = CW'(depth);
    localparam logic [CW-1:0] DELAY_C    = CW'(delay);
    localparam logic [PW-1:0] LAST_PTR_C = PW'(depth - 1);

    if (depth < delay + 2) begin : g_bad_depth
        $error("dfc_rx_buffer: depth must be >= delay+2");
    end

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          c_drdy_q, c_drdy_d;
    logic          pop;
    logic          push_ok;

    // depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR_C) ? '0 : p + PW'(1);
    endfunction

    assign p_srdy = (count_q != '0);

    always_comb begin
        pop     = p_srdy & p_drdy;
        // A full FIFO still accepts a beat when the head leaves in the same cycle.
        push_ok = c_srdy & ((count_q < DEPTH_C) | pop);

        count_d    = count_q + CW'(push_ok) - CW'(pop);
        wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        overflow_d = overflow_q | (c_srdy & ~push_ok);

        // Decided on next-state occupancy: with more than `delay` free slots,
        // the beats already in flight when the sender sees STOP always fit.
        c_drdy_d = ((DEPTH_C - count_d) > DELAY_C) ? DFC_GO : DFC_STOP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            c_drdy_q   <= DFC_STOP;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            c_drdy_q   <= c_drdy_d;
        end
    end

    dfc_rx_buffer_mem #(
        .width (width),
        .depth (depth),
        .aw    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (c_data),
        .rd_addr (rd_ptr_q),
        .rd_data (p_data)
    );

    assign usage    = count_q;
    assign overflow = overflow_q;
    assign c_drdy   = c_drdy_q;

endmodule

// File: tb/tb_dfc_rx_buffer.sv
module tb_dfc_rx_buffer;

    logic       clk;
    logic       rst    [2];
    logic       c_srdy [2];
    logic [7:0] c_data [2];
    logic       c_drdy [2];
    logic       p_srdy [2];
    logic       p_drdy [2];
    logic [7:0] p_data [2];
    logic       ovf    [2];
    logic [3:0] usage_a;
    logic [2:0] usage_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dfc_rx_buffer #(.width(8), .depth(8), .delay(3)) u_dut_a (
        .clk(clk), .reset(rst[0]), .c_srdy(c_srdy[0]), .c_data(c_data[0]),
        .c_drdy(c_drdy[0]), .p_srdy(p_srdy[0]), .p_drdy(p_drdy[0]),
        .p_data(p_data[0]), .usage(usage_a), .overflow(ovf[0])
    );

    dfc_rx_buffer #(.width(8), .depth(6), .delay(3)) u_dut_b (
        .clk(clk), .reset(rst[1]), .c_srdy(c_srdy[1]), .c_data(c_data[1]),
        .c_drdy(c_drdy[1]), .p_srdy(p_srdy[1]), .p_drdy(p_drdy[1]),
        .p_data(p_data[1]), .usage(usage_b), .overflow(ovf[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops expected beats whenever a DUT hands one over downstream.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst[0] && p_srdy[0] && p_drdy[0]) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_pop_unexpected: got=%0h expected=none", p_data[0]);
                end else begin
                    e = q0.pop_front();
                    chk("a_pop_data", {24'd0, p_data[0]}, {24'd0, e});
                end
            end
            if (!rst[1] && p_srdy[1] && p_drdy[1]) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_pop_unexpected: got=%0h expected=none", p_data[1]);
                end else begin
                    e = q1.pop_front();
                    chk("b_pop_data", {24'd0, p_data[1]}, {24'd0, e});
                end
            end
        end
    endtask

    // Eight back-to-back beats into instance a with p_drdy low.
    task automatic fill_a(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            c_srdy[0] = 1'b1;
            c_data[0] = base + 8'(i);
            q0.push_back(base + 8'(i));
            if (i == 4) chk("a_drdy_cycle4", 32'(c_drdy[0]), 32'd1);
            if (i == 5) chk("a_drdy_cycle5", 32'(c_drdy[0]), 32'd0);
            tick();
        end
        c_srdy[0] = 1'b0;
    endtask

    // Drain a full instance a; c_drdy returns once usage reaches 4.
    task automatic drain_a();
        p_drdy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                chk("a_drain_usage5", 32'(usage_a), 32'd5);
                chk("a_drain_drdy_lo", 32'(c_drdy[0]), 32'd0);
            end
            if (i == 4) begin
                chk("a_drain_usage4", 32'(usage_a), 32'd4);
                chk("a_drain_drdy_hi", 32'(c_drdy[0]), 32'd1);
            end
            tick();
        end
        p_drdy[0] = 1'b0;
        chk("a_drain_empty", 32'(usage_a), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; c_srdy[k] = 1'b0; c_data[k] = 8'h00; p_drdy[k] = 1'b0;
        end
        fork
            monitor();
        join_none

        // Reset then idle
        tick(); tick();
        chk("rst_drdy", 32'(c_drdy[0]), 32'd0);
        chk("rst_psrdy", 32'(p_srdy[0]), 32'd0);
        chk("rst_usage", 32'(usage_a), 32'd0);
        chk("rst_ovf", 32'(ovf[0]), 32'd0);
        rst[0] = 1'b0;
        tick();
        chk("drdy_after_rst", 32'(c_drdy[0]), 32'd1);
        chk("psrdy_after_rst", 32'(p_srdy[0]), 32'd0);

        // Single beat, one-cycle latency
        c_srdy[0] = 1'b1; c_data[0] = 8'h11; p_drdy[0] = 1'b1;
        q0.push_back(8'h11);
        tick();
        c_srdy[0] = 1'b0;
        chk("single_psrdy", 32'(p_srdy[0]), 32'd1);
        chk("single_pdata", 32'(p_data[0]), 32'h11);
        chk("single_usage1", 32'(usage_a), 32'd1);
        tick();
        chk("single_usage0", 32'(usage_a), 32'd0);
        chk("single_psrdy0", 32'(p_srdy[0]), 32'd0);
        p_drdy[0] = 1'b0;

        // Fill to full, then drain in order
        fill_a(8'h00);
        chk("full_usage", 32'(usage_a), 32'd8);
        chk("full_ovf", 32'(ovf[0]), 32'd0);
        chk("full_drdy", 32'(c_drdy[0]), 32'd0);
        drain_a();

        // Ninth beat on a full FIFO is dropped
        fill_a(8'h20);
        c_srdy[0] = 1'b1; c_data[0] = 8'hFF;
        tick();
        c_srdy[0] = 1'b0;
        chk("ovf_set", 32'(ovf[0]), 32'd1);
        chk("ovf_usage", 32'(usage_a), 32'd8);
        drain_a();
        chk("ovf_sticky", 32'(ovf[0]), 32'd1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("ovf_cleared", 32'(ovf[0]), 32'd0);
        chk("drdy_in_rst", 32'(c_drdy[0]), 32'd0);
        tick();

        // Full FIFO with simultaneous push and pop
        fill_a(8'h50);
        c_srdy[0] = 1'b1; c_data[0] = 8'hAA; p_drdy[0] = 1'b1;
        q0.push_back(8'hAA);
        tick();
        c_srdy[0] = 1'b0; p_drdy[0] = 1'b0;
        chk("pp_usage", 32'(usage_a), 32'd8);
        chk("pp_ovf", 32'(ovf[0]), 32'd0);
        drain_a();

        // Instance b (depth 6): overflow, mid-operation reset, wrap
        rst[1] = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            c_srdy[1] = 1'b1;
            c_data[1] = 8'h60 + 8'(i);
            if (i < 6) q1.push_back(8'h60 + 8'(i));
            tick();
        end
        c_srdy[1] = 1'b0; p_drdy[1] = 1'b1;
        tick();
        p_drdy[1] = 1'b0;
        chk("b_usage5", 32'(usage_b), 32'd5);
        chk("b_ovf_set", 32'(ovf[1]), 32'd1);
        rst[1] = 1'b1;
        q1.delete();
        tick();
        rst[1] = 1'b0;
        chk("b_rst_usage", 32'(usage_b), 32'd0);
        chk("b_rst_psrdy", 32'(p_srdy[1]), 32'd0);
        chk("b_rst_ovf", 32'(ovf[1]), 32'd0);
        c_srdy[1] = 1'b1; c_data[1] = 8'h33;
        q1.push_back(8'h33);
        tick();
        chk("b_first_psrdy", 32'(p_srdy[1]), 32'd1);
        chk("b_first_pdata", 32'(p_data[1]), 32'h33);
        p_drdy[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c_data[1] = 8'h80 + 8'(i);
            q1.push_back(8'h80 + 8'(i));
            tick();
        end
        c_srdy[1] = 1'b0;
        tick(); tick();
        chk("b_wrap_empty", 32'(usage_b), 32'd0);
        chk("b_wrap_ovf", 32'(ovf[1]), 32'd0);
        p_drdy[1] = 1'b0;

        tick();
        chk("a_all_popped", 32'(q0.size()), 32'd0);
        chk("b_all_popped", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
